// File: rtl/adc_scan_sequencer_pkg.sv
// Shared definitions for the ADC scan sequencer: default sizes and the
// sequencer state encoding.
package adc_scan_sequencer_pkg;
  localparam int W_DEF    = 8;
  localparam int N_CH_DEF = 4;
  localparam int CHW_DEF  = 2;

  typedef enum logic [2:0] {
    ST_PICK,
    ST_SETTLE,
    ST_START,
    ST_CONV,
    ST_OFFER,
    ST_ACK
  } state_t;
endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Converter-side (sel/soc/eoc/x) and consumer-side (dav_/rfd/data/chan)
// signals of the scan sequencer. master = sequencer, slave = environment.
interface adc_scan_sequencer_if
  import adc_scan_sequencer_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int CHW = CHW_DEF
);
  logic [CHW-1:0] sel;
  logic           soc;
  logic           eoc;
  logic [W-1:0]   x;
  logic           dav_;
  logic           rfd;
  logic [W-1:0]   data;
  logic [CHW-1:0] chan;

  modport master (output sel, soc, dav_, data, chan, input eoc, x, rfd);
  modport slave  (input sel, soc, dav_, data, chan, output eoc, x, rfd);
endinterface

// File: rtl/adc_scan_sequencer_rr_next_channel.sv
// Round-robin channel picker: first enabled channel after i_last,
// scanning upward with wrap-around. o_any flags a non-empty mask.
module rr_next_channel #(
  parameter int N_CH = 4,
  parameter int CHW  = 2
) (
  input  logic [CHW-1:0]  i_last,
  input  logic [N_CH-1:0] i_ch_en,
  output logic [CHW-1:0]  o_next,
  output logic            o_any
);
  logic w_found;
  int   w_idx;

  // Scan last+1 .. last+N_CH; the final step revisits last itself, so a
  // single enabled channel is picked again on every pass.
  always_comb begin
    o_next  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = (int'(i_last) + k) % N_CH;
      if (!w_found && i_ch_en[w_idx]) begin
        o_next  = CHW'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  assign o_any = |i_ch_en;
endmodule

// File: rtl/adc_scan_sequencer.sv
// Shares one A/D converter across N_CH mux inputs: picks the next enabled
// channel, lets the mux settle, runs soc/eoc, then hands the sample to the
// consumer over dav_/rfd. Conversion and delivery never overlap.
module adc_scan_sequencer
  import adc_scan_sequencer_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int N_CH = N_CH_DEF,
  parameter int CHW  = CHW_DEF
) (
  input  logic            clock,
  input  logic            reset_,
  input  logic [N_CH-1:0] ch_en,
  adc_scan_sequencer_if.master bus
);
  state_t         r_state, w_state_nxt;
  logic [CHW-1:0] r_sel, r_last, r_chan;
  logic [W-1:0]   r_data;
  logic           r_dav_n;
  logic [CHW-1:0] w_next_ch;
  logic           w_any;

  rr_next_channel #(.N_CH(N_CH), .CHW(CHW)) u_rr (
    .i_last (r_last),
    .i_ch_en(ch_en),
    .o_next (w_next_ch),
    .o_any  (w_any)
  );

  // Next-state logic; ch_en only matters while in PICK.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PICK:   if (w_any)     w_state_nxt = ST_SETTLE;
      ST_SETTLE:                w_state_nxt = ST_START;
      ST_START:  if (!bus.eoc)  w_state_nxt = ST_CONV;
      ST_CONV:   if (bus.eoc)   w_state_nxt = ST_OFFER;
      ST_OFFER:  if (bus.rfd)   w_state_nxt = ST_ACK;
      ST_ACK:    if (!bus.rfd)  w_state_nxt = ST_PICK;
      default:                  w_state_nxt = ST_PICK;
    endcase
  end

  // State register; reset abandons any conversion or delivery.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) r_state <= ST_PICK;
    else         r_state <= w_state_nxt;
  end

  // Datapath: sel moves only in PICK, capture on eoc return, dav_ handshake.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_sel   <= '0;
      r_last  <= CHW'(N_CH - 1);
      r_data  <= '0;
      r_chan  <= '0;
      r_dav_n <= 1'b1;
    end else begin
      if (r_state == ST_PICK && w_any) r_sel <= w_next_ch;
      if (r_state == ST_CONV && bus.eoc) begin
        r_data <= bus.x;
        r_chan <= r_sel;
        r_last <= r_sel;
      end
      if (r_state == ST_OFFER && bus.rfd)  r_dav_n <= 1'b0;
      if (r_state == ST_ACK   && !bus.rfd) r_dav_n <= 1'b1;
    end
  end

  assign bus.sel  = r_sel;
  assign bus.soc  = (r_state == ST_START);
  assign bus.dav_ = r_dav_n;
  assign bus.data = r_data;
  assign bus.chan = r_chan;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: behavioural converter, table of scan
// vectors, hand-written corner sequences and a randomized run against a
// round-robin reference model.
module tb_adc_scan_sequencer;
  logic       clock;
  logic       reset_;
  logic [3:0] ch_en;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] lut [4];

  adc_scan_sequencer_if #(.W(8), .CHW(2)) bus ();

  adc_scan_sequencer #(.W(8), .N_CH(4), .CHW(2)) dut (
    .clock (clock),
    .reset_(reset_),
    .ch_en (ch_en),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Converter: on soc goes busy for 1..4 clocks, output garbage while busy,
  // then presents lut[sel] with eoc=1.
  initial begin
    int cnt;
    cnt = 0;
    bus.eoc = 1'b1;
    bus.x   = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_) begin
        bus.eoc = 1'b1;
        cnt     = 0;
      end else if (bus.eoc && bus.soc) begin
        cnt     = int'($urandom_range(1, 4));
        bus.eoc = 1'b0;
        bus.x   = 8'($urandom);
      end else if (!bus.eoc) begin
        if (cnt > 1) begin
          cnt--;
          bus.x = 8'($urandom);
        end else begin
          bus.x   = lut[bus.sel];
          bus.eoc = 1'b1;
        end
      end
    end
  end

  // Protocol monitor: serialization, mux settling, sel stable over conversion.
  logic [1:0] m_prev_sel, m_conv_sel;
  logic       m_prev_soc;
  bit         m_act, m_busy;
  initial begin
    m_prev_sel = '0; m_conv_sel = '0; m_prev_soc = 1'b0; m_act = 0; m_busy = 0;
    forever begin
      @(negedge clock);
      if (!reset_) begin
        m_act = 0;
        m_prev_soc = 1'b0;
      end else begin
        if (bus.soc) chk("soc_while_dav", bus.dav_, 1'b1);
        if (bus.soc && !m_prev_soc) begin
          chk("sel_settle", bus.sel, m_prev_sel);
          m_act = 1; m_busy = 0; m_conv_sel = bus.sel;
        end
        if (m_act) begin
          chk("sel_stable_conv", bus.sel, m_conv_sel);
          if (!bus.eoc) m_busy = 1;
          else if (m_busy) m_act = 0;
        end
        m_prev_soc = bus.soc;
      end
      m_prev_sel = bus.sel;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_eoc(input logic v);
    int n = 0;
    while (bus.eoc !== v && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("wait_eoc", bus.eoc, v);
  endtask

  // Consumer: idle pre clocks with rfd=0, raise rfd, take the sample on dav_=0,
  // then acknowledge with rfd=0.
  task automatic recv(input int pre, output logic [1:0] c, output logic [7:0] d);
    int n = 0;
    bus.rfd = 1'b0;
    repeat (pre) @(negedge clock);
    bus.rfd = 1'b1;
    while (bus.dav_ !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("dav_timeout", bus.dav_, 1'b0);
    c = bus.chan;
    d = bus.data;
    bus.rfd = 1'b0;
    @(negedge clock);
    chk("dav_release", bus.dav_, 1'b1);
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
  endtask

  // Reference: lowest enabled channel above last, else lowest enabled.
  function automatic int rr_ref(input int last, input logic [3:0] m);
    int q[$];
    for (int i = 0; i < 4; i++) if (m[i]) q.push_back(i);
    foreach (q[j]) if (q[j] > last) return q[j];
    return q[0];
  endfunction

  typedef struct {
    logic [3:0] mask;
    int         pre;
    int         c;
    int         d;
  } vec_t;
  vec_t tbl [9];

  initial begin
    logic [1:0] c;
    logic [7:0] d;
    int last, ec;
    tbl[0] = '{4'b1111, 0, 0, 10};
    tbl[1] = '{4'b1111, 2, 1, 20};
    tbl[2] = '{4'b1111, 0, 2, 30};
    tbl[3] = '{4'b1111, 5, 3, 40};
    tbl[4] = '{4'b1111, 1, 0, 10};
    tbl[5] = '{4'b1010, 0, 1, 20};
    tbl[6] = '{4'b1010, 3, 3, 40};
    tbl[7] = '{4'b1010, 0, 1, 20};
    tbl[8] = '{4'b1010, 1, 3, 40};
    lut[0] = 8'd10; lut[1] = 8'd20; lut[2] = 8'd30; lut[3] = 8'd40;

    reset_ = 1'b0; ch_en = 4'b0000; bus.rfd = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_soc", bus.soc, 1'b0);
    chk("rst_dav", bus.dav_, 1'b1);
    chk("rst_sel", bus.sel, 2'd0);
    chk("rst_data", bus.data, 8'd0);
    chk("rst_chan", bus.chan, 2'd0);
    reset_ = 1'b1;

    // Reset in the middle of a conversion of channel 2.
    ch_en = 4'b0100;
    wait_eoc(1'b0);
    chk("pre_rst_sel", bus.sel, 2'd2);
    reset_ = 1'b0;
    #1;
    chk("async_rst_soc", bus.soc, 1'b0);
    chk("async_rst_dav", bus.dav_, 1'b1);
    chk("async_rst_sel", bus.sel, 2'd0);
    @(negedge clock);
    @(negedge clock);
    reset_ = 1'b1;

    // Full scan, then sparse mask starting from a fresh reset (last=3).
    for (int i = 0; i < 9; i++) begin
      if (i == 5) do_reset();
      ch_en = tbl[i].mask;
      recv(tbl[i].pre, c, d);
      chk($sformatf("tbl%0d_chan", i), c, tbl[i].c);
      chk($sformatf("tbl%0d_data", i), d, tbl[i].d);
    end

    // Empty mask: no activity, then enabling channel 2 starts after SETTLE.
    ch_en = 4'b0000;
    repeat (20) begin
      @(negedge clock);
      chk("empty_soc", bus.soc, 1'b0);
      chk("empty_dav", bus.dav_, 1'b1);
    end
    ch_en = 4'b0100;
    @(negedge clock);
    chk("settle_soc", bus.soc, 1'b0);
    chk("settle_sel", bus.sel, 2'd2);
    @(negedge clock);
    chk("start_soc", bus.soc, 1'b1);
    chk("start_sel", bus.sel, 2'd2);
    recv(0, c, d);
    chk("empty_chan", c, 2'd2);
    chk("empty_data", d, 8'd30);

    // Mask change during a conversion applies at the next pick.
    ch_en = 4'b0001;
    wait_eoc(1'b0);
    ch_en = 4'b0010;
    recv(0, c, d);
    chk("chg_chan0", c, 2'd0);
    chk("chg_data0", d, 8'd10);
    recv(0, c, d);
    chk("chg_chan1", c, 2'd1);
    chk("chg_data1", d, 8'd20);

    // Slow consumer holding rfd=0 after capture of 8'h5A.
    lut[2] = 8'h5A;
    ch_en = 4'b0100;
    bus.rfd = 1'b0;
    wait_eoc(1'b0);
    wait_eoc(1'b1);
    @(negedge clock);
    repeat (15) begin
      @(negedge clock);
      chk("slow_dav", bus.dav_, 1'b1);
      chk("slow_soc", bus.soc, 1'b0);
    end
    bus.rfd = 1'b1;
    @(negedge clock);
    chk("slow_dav_fall", bus.dav_, 1'b0);
    chk("slow_data", bus.data, 8'h5A);
    chk("slow_chan", bus.chan, 2'd2);
    repeat (3) begin
      @(negedge clock);
      chk("slow_no_soc", bus.soc, 1'b0);
    end
    bus.rfd = 1'b0;
    @(negedge clock);
    chk("slow_ack", bus.dav_, 1'b1);
    last = 2;

    // Randomized masks, sample values and consumer delays.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) lut[k] = 8'($urandom);
      ch_en = 4'($urandom_range(1, 15));
      ec = rr_ref(last, ch_en);
      recv(int'($urandom_range(0, 3)), c, d);
      chk($sformatf("rnd%0d_chan", i), c, ec);
      chk($sformatf("rnd%0d_data", i), d, lut[ec]);
      last = ec;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
